adc_avg_cal: RTL and testbench
==============================

ADC_AVG_CAL -- requirements
Module: adc_avg_cal

Interface
REQ-001 SHALL have parameters: ADC_WIDTH, default 12, ADC sample width (two's complement); FP_WIDTH, default 32, Q16.16 word width; AVG_LOG2, default 10, log2 of samples per average (legal 1..16).
REQ-002 SHALL have one clock; reset is synchronous and active-low: ADC_CLK input 1 rising-edge clock; RST_N input 1 synchronous active-low reset.
REQ-003 ADC_IN input ADC_WIDTH: raw signed ADC sample, one per clock.
REQ-004 START input 1: single-cycle request to begin one averaging run.
REQ-005 CAL_GAIN input FP_WIDTH: signed Q16.16 gain.
REQ-006 CAL_OFFSET input FP_WIDTH: signed Q16.16 offset.
REQ-007 AVG_OUT output FP_WIDTH: signed Q16.16 calibrated average, held until next result.
REQ-008 AVG_VALID output 1: one-cycle pulse when AVG_OUT updates.
REQ-009 BUSY output 1: high while a run is in progress.

Function
REQ-010 States SHALL be IDLE, CAPTURE, DRAIN, PUBLISH; N = 2^AVG_LOG2.
REQ-011 IDLE: START=1 at edge t0 -> CAPTURE, BUSY=1, CAL_GAIN/CAL_OFFSET latched; accumulator cleared.
REQ-012 CAPTURE: ADC_IN registered with a valid tag at edges t0+1..t0+N (N consecutive samples, no gaps); sample counter reaching N-1 -> DRAIN.
REQ-013 Pipeline per tagged sample: edge+1 product = sign-extended ADC_IN x latched gain (ADC_WIDTH+FP_WIDTH bits, full precision, result in Q16.16); edge+2 calibrated = product + latched offset, saturated to FP_WIDTH signed (0x7FFFFFFF / 0x80000000); edge+3 accumulate into FP_WIDTH+AVG_LOG2-bit signed accumulator (no overflow possible).
REQ-014 DRAIN: lasts until last tagged sample is accumulated (edge t0+N+3), then PUBLISH.
REQ-015 PUBLISH (edge t0+N+4): AVG_OUT = accumulator arithmetically shifted right by AVG_LOG2 (floor), AVG_VALID=1 for exactly one cycle, BUSY=0, state -> IDLE.
REQ-016 Total latency START edge to AVG_VALID edge SHALL be exactly N+4 cycles.
REQ-017 START while BUSY=1 (including the PUBLISH edge) SHALL be ignored, not queued.
REQ-018 CAL_GAIN/CAL_OFFSET changes during a run SHALL NOT affect that run.
REQ-019 START in IDLE on the cycle after PUBLISH SHALL be accepted (back-to-back runs, N+5-cycle period).
REQ-020 Untagged pipeline contents SHALL never reach the accumulator.

Reset
REQ-021 RST_N=0 at any edge, including mid-run: state IDLE, AVG_OUT=0, AVG_VALID=0, BUSY=0, counters, tags, accumulator and latched calibration cleared; aborted run produces no AVG_VALID.
REQ-022 START coincident with RST_N=0 SHALL be ignored.

Verification
REQ-023 Gain 0x00010000, offset 0, ADC_IN=100 constant, START at t0 -> AVG_VALID at t0+1028, AVG_OUT=0x00640000, BUSY falls same edge.
REQ-024 Gain 0x00011A7B, offset 0xFFFFFD3D, ADC_IN=0 -> AVG_OUT=0xFFFFFD3D.
REQ-025 Gain 0x00010000, offset 0, ADC_IN ramp 0..1023 over capture window -> AVG_OUT=0x01FF8000 (511.5).
REQ-026 Gain 0x7FFFFFFF, offset 0: ADC_IN=2047 -> AVG_OUT=0x7FFFFFFF; ADC_IN=-2048 -> AVG_OUT=0x80000000.
REQ-027 START again at t0+500 during run and CAL_GAIN changed at t0+10 -> single AVG_VALID at t0+1028 with value computed from gain latched at t0.
REQ-028 RST_N low at t0+600 for one cycle -> no AVG_VALID, all outputs 0; subsequent START at t1 -> normal result at t1+1028.

Source files
------------

// File: rtl/adc_avg_cal.sv
// Streaming ADC averager: 2**AVG_LOG2 consecutive samples are gain/offset
// calibrated in Q16.16, summed, and published as a floored mean.
module adc_avg_cal #(
    parameter int ADC_WIDTH = 12,
    parameter int FP_WIDTH  = 32,
    parameter int AVG_LOG2  = 10
) (
    input  logic                 ADC_CLK,
    input  logic                 RST_N,
    input  logic [ADC_WIDTH-1:0] ADC_IN,
    input  logic                 START,
    input  logic [FP_WIDTH-1:0]  CAL_GAIN,
    input  logic [FP_WIDTH-1:0]  CAL_OFFSET,
    output logic [FP_WIDTH-1:0]  AVG_OUT,
    output logic                 AVG_VALID,
    output logic                 BUSY,
    output logic [1:0]           dbg_state
);
    localparam int PW = ADC_WIDTH + FP_WIDTH;
    localparam int SW = PW + 1;
    localparam int AW = FP_WIDTH + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, PUBLISH} state_t;

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                publish;

    logic [AVG_LOG2-1:0] sample_cnt;
    logic [1:0]          drain_cnt;
    logic [FP_WIDTH-1:0] gain_q;
    logic [FP_WIDTH-1:0] offset_q;

    logic                s0_vld;
    logic                s1_vld;
    logic                s2_vld;
    logic [ADC_WIDTH-1:0] s0_data;
    logic signed [PW-1:0] s1_prod;
    logic [FP_WIDTH-1:0] s2_cal;
    logic [AW-1:0]       acc;

    logic signed [PW-1:0] prod_w;
    logic signed [SW-1:0] sum_w;
    logic [FP_WIDTH-1:0] cal_w;

    // Handshake: START is a one-cycle request honoured only while BUSY=0
    // (IDLE); otherwise it is dropped. AVG_VALID qualifies AVG_OUT for exactly
    // one cycle with no backpressure; AVG_OUT then holds until the next result.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        publish   = 1'b0;
        case (state)
            IDLE: begin
                if (START) begin
                    accept    = 1'b1;
                    state_nxt = CAPTURE;
                end
            end
            CAPTURE: if (sample_cnt == CNT_LAST) state_nxt = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) state_nxt = PUBLISH;
            PUBLISH: begin
                publish   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Full-precision product, then offset add with clamp to the Q16.16 range.
    always_comb begin
        prod_w = $signed({{FP_WIDTH{s0_data[ADC_WIDTH-1]}}, s0_data})
               * $signed({{ADC_WIDTH{gain_q[FP_WIDTH-1]}}, gain_q});
        sum_w  = $signed({s1_prod[PW-1], s1_prod})
               + $signed({{(SW-FP_WIDTH){offset_q[FP_WIDTH-1]}}, offset_q});
        cal_w  = sum_w[FP_WIDTH-1:0];
        if (!((&sum_w[SW-1:FP_WIDTH-1]) || (~|sum_w[SW-1:FP_WIDTH-1]))) begin
            cal_w = sum_w[SW-1] ? {1'b1, {(FP_WIDTH-1){1'b0}}}
                                : {1'b0, {(FP_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge ADC_CLK) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge ADC_CLK) begin
        if (!RST_N) begin
            sample_cnt <= '0;
            drain_cnt  <= '0;
            gain_q     <= '0;
            offset_q   <= '0;
            s0_vld     <= 1'b0;
            s1_vld     <= 1'b0;
            s2_vld     <= 1'b0;
            s0_data    <= '0;
            s1_prod    <= '0;
            s2_cal     <= '0;
            acc        <= '0;
            AVG_OUT    <= '0;
            AVG_VALID  <= 1'b0;
        end else begin
            s0_vld    <= (state == CAPTURE);
            s0_data   <= ADC_IN;
            s1_vld    <= s0_vld;
            s1_prod   <= prod_w;
            s2_vld    <= s1_vld;
            s2_cal    <= cal_w;
            AVG_VALID <= publish;

            if (state == CAPTURE) sample_cnt <= sample_cnt + AVG_LOG2'(1);
            else                  sample_cnt <= '0;
            if (state == DRAIN)   drain_cnt  <= drain_cnt + 2'd1;
            else                  drain_cnt  <= '0;

            if (accept) begin
                gain_q   <= CAL_GAIN;
                offset_q <= CAL_OFFSET;
                acc      <= '0;
            end else if (s2_vld) begin
                acc <= acc + {{AVG_LOG2{s2_cal[FP_WIDTH-1]}}, s2_cal};
            end

            // Dropping the low AVG_LOG2 bits is the floored arithmetic shift.
            if (publish) AVG_OUT <= acc[AW-1:AVG_LOG2];
        end
    end

    assign BUSY      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_adc_avg_cal.sv
// Directed bench for adc_avg_cal: expected averages are queued at START and
// compared when AVG_VALID is due, along with reset, hold and abort behaviour.
module tb_adc_avg_cal;
    localparam int ADC_W = 12;
    localparam int FP_W  = 32;
    localparam int LOG2  = 10;
    localparam int N     = 1 << LOG2;

    logic             ADC_CLK = 1'b0;
    logic             RST_N;
    logic             START;
    logic [ADC_W-1:0] ADC_IN;
    logic [FP_W-1:0]  CAL_GAIN;
    logic [FP_W-1:0]  CAL_OFFSET;
    logic [FP_W-1:0]  AVG_OUT;
    logic             AVG_VALID;
    logic             BUSY;
    logic [1:0]       dbg_state;

    int cyc      = 0;
    int n_checks = 0;
    int n_pass   = 0;

    logic [FP_W-1:0]         exp_q[$];
    int                      exp_cyc_q[$];
    logic signed [ADC_W-1:0] samples [N];

    adc_avg_cal #(
        .ADC_WIDTH (ADC_W),
        .FP_WIDTH  (FP_W),
        .AVG_LOG2  (LOG2)
    ) dut (
        .ADC_CLK    (ADC_CLK),
        .RST_N      (RST_N),
        .ADC_IN     (ADC_IN),
        .START      (START),
        .CAL_GAIN   (CAL_GAIN),
        .CAL_OFFSET (CAL_OFFSET),
        .AVG_OUT    (AVG_OUT),
        .AVG_VALID  (AVG_VALID),
        .BUSY       (BUSY),
        .dbg_state  (dbg_state)
    );

    // Clock and edge counter: at a negedge, cyc equals the number of rising
    // edges seen so far.
    always #5 ADC_CLK = ~ADC_CLK;
    always @(posedge ADC_CLK) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [ADC_W-1:0] junk();
        return ADC_W'($urandom_range(0, 4095));
    endfunction

    // Reference: per-sample Q16.16 product plus offset, clamped to 32 bits,
    // summed in 64-bit and floored by the sample count.
    function automatic logic [31:0] model(input logic [31:0] gain, input logic [31:0] off);
        longint acc;
        longint s;
        longint max_v;
        longint min_v;
        max_v = longint'(32'sh7FFF_FFFF);
        min_v = longint'(32'sh8000_0000);
        acc = 0;
        for (int k = 0; k < N; k++) begin
            s = longint'(samples[k]) * longint'($signed(gain)) + longint'($signed(off));
            if (s > max_v)      s = max_v;
            else if (s < min_v) s = min_v;
            acc += s;
        end
        acc = acc >>> LOG2;
        return acc[31:0];
    endfunction

    // kind 0: constant val, 1: ramp 0..N-1, otherwise random codes.
    task automatic fill(input int kind, input int val);
        for (int k = 0; k < N; k++) begin
            case (kind)
                0:       samples[k] = ADC_W'(val);
                1:       samples[k] = ADC_W'(k);
                default: samples[k] = ADC_W'($urandom_range(0, 4095));
            endcase
        end
    endtask

    // Called at a negedge; START is seen at edge t0, result due at t0+N+4.
    task automatic start_run(input logic [31:0] gain, input logic [31:0] off,
                             input logic [31:0] exp_val, output int t0);
        CAL_GAIN   = gain;
        CAL_OFFSET = off;
        START      = 1'b1;
        ADC_IN     = junk();
        @(negedge ADC_CLK);
        START = 1'b0;
        t0    = cyc;
        exp_q.push_back(exp_val);
        exp_cyc_q.push_back(t0 + N + 4);
    endtask

    // Drives samples for edges t0+1..t0+N; optionally disturbs the run.
    task automatic feed(input bit disturb, input int abort_k);
        for (int k = 0; k < N; k++) begin
            if (k == 0) begin
                check("busy_in_run", 32'(BUSY), 32'd1);
                check("state_capture", 32'(dbg_state), 32'd1);
            end
            if (disturb && k == 9) begin
                CAL_GAIN   = $urandom();
                CAL_OFFSET = $urandom();
            end
            if (disturb) START = (k == 499);
            if (k == abort_k) RST_N = 1'b0;
            if (abort_k >= 0 && k == abort_k + 1) begin
                RST_N = 1'b1;
                check("abort_avg_out", AVG_OUT, 32'd0);
                check("abort_valid", 32'(AVG_VALID), 32'd0);
                check("abort_busy", 32'(BUSY), 32'd0);
                check("abort_state", 32'(dbg_state), 32'd0);
                void'(exp_q.pop_back());
                void'(exp_cyc_q.pop_back());
            end
            ADC_IN = samples[k];
            @(negedge ADC_CLK);
        end
    endtask

    // Runs out the pipeline; poke drives START into the PUBLISH edge.
    task automatic tail(input bit poke);
        repeat (3) begin
            ADC_IN = junk();
            @(negedge ADC_CLK);
        end
        START  = poke;
        ADC_IN = junk();
        @(negedge ADC_CLK);
        START = 1'b0;
    endtask

    // Scoreboard: pop and compare when a result is due; flag stray pulses.
    always @(negedge ADC_CLK) begin
        if (exp_cyc_q.size() != 0 && cyc == exp_cyc_q[0]) begin
            check("avg_valid", 32'(AVG_VALID), 32'd1);
            check("avg_out", AVG_OUT, exp_q[0]);
            check("busy_fall", 32'(BUSY), 32'd0);
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end else if (AVG_VALID) begin
            check("unexpected_valid", 32'(AVG_VALID), 32'd0);
        end
    end

    initial begin
        int          t0;
        logic [31:0] g;
        logic [31:0] o;

        RST_N      = 1'b0;
        START      = 1'b1;
        ADC_IN     = '0;
        CAL_GAIN   = '1;
        CAL_OFFSET = '1;
        repeat (3) @(negedge ADC_CLK);
        check("rst_avg_out", AVG_OUT, 32'd0);
        check("rst_valid", 32'(AVG_VALID), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        RST_N = 1'b1;
        START = 1'b0;
        repeat (3) @(negedge ADC_CLK);
        check("idle_busy", 32'(BUSY), 32'd0);
        check("idle_state", 32'(dbg_state), 32'd0);

        // Unity gain, constant 100; START poked at the PUBLISH edge.
        fill(0, 100);
        start_run(32'h0001_0000, 32'h0, 32'h0064_0000, t0);
        feed(1'b0, -1);
        tail(1'b1);
        @(negedge ADC_CLK);
        check("publish_start_ignored", 32'(BUSY), 32'd0);
        check("valid_one_cycle", 32'(AVG_VALID), 32'd0);
        check("avg_out_held", AVG_OUT, 32'h0064_0000);

        // Zero input exposes the offset alone; followed back-to-back by a ramp.
        fill(0, 0);
        start_run(32'h0001_1A7B, 32'hFFFF_FD3D, 32'hFFFF_FD3D, t0);
        feed(1'b0, -1);
        tail(1'b0);
        fill(1, 0);
        start_run(32'h0001_0000, 32'h0, 32'h01FF_8000, t0);
        feed(1'b0, -1);
        tail(1'b0);

        // Saturation at both rails.
        fill(0, 2047);
        start_run(32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, t0);
        feed(1'b0, -1);
        tail(1'b0);
        fill(0, -2048);
        start_run(32'h7FFF_FFFF, 32'h0, 32'h8000_0000, t0);
        feed(1'b0, -1);
        tail(1'b0);

        // Calibration changed and START re-pulsed mid-run.
        fill(2, 0);
        g = 32'h0001_8000;
        o = 32'h0000_2000;
        start_run(g, o, model(g, o), t0);
        feed(1'b1, -1);
        tail(1'b0);

        // Reset at t0+600 aborts the run; no result may appear.
        fill(2, 0);
        start_run(g, o, model(g, o), t0);
        feed(1'b0, 599);
        tail(1'b0);
        check("abort_no_valid", 32'(AVG_VALID), 32'd0);

        // Fresh run after the abort with random calibration.
        fill(2, 0);
        g = $urandom();
        o = $urandom();
        start_run(g, o, model(g, o), t0);
        feed(1'b0, -1);
        tail(1'b0);

        repeat (5) @(negedge ADC_CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
